// File: rtl/clk_sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_sw_pkg
// Description : Shared types and constants for the clock-switch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_sw_pkg;

    // Default width of the settle counter and of the settle request field
    localparam int CLK_SW_CNT_W = 8;

    // Sequencer states: gate off, change select, restore gate, report
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OFF_WAIT = 3'd1,
        SEL_WAIT = 3'd2,
        ON_WAIT  = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/clk_sw_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_sw_ctrl_if
// Description : Request handshake and clock-control outputs of the clock-switch
//               sequencer. master = requester side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_sw_ctrl_if
    import clk_sw_pkg::*;
#(
    parameter int CNT_W = CLK_SW_CNT_W
) ();

    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_sel_i;
    logic             req_en_i;
    logic [CNT_W-1:0] settle_i;
    logic             clk_sel_o;
    logic             clk_en_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output req_valid_i,
        output req_sel_i,
        output req_en_i,
        output settle_i,
        input  req_ready_o,
        input  clk_sel_o,
        input  clk_en_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  req_valid_i,
        input  req_sel_i,
        input  req_en_i,
        input  settle_i,
        output req_ready_o,
        output clk_sel_o,
        output clk_en_o,
        output busy_o,
        output done_o
    );

endinterface
`default_nettype wire

// File: rtl/clk_sw_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : clk_sw_settle_cnt
// Description : Loadable down-counter timing each settle phase. is_last_o
//               flags the final cycle of a phase (count == 1).
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sw_settle_cnt #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_val_i,
    input  wire logic             dec_i,
    output logic                  is_last_o
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero so the count never wraps
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (dec_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign is_last_o = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/clk_sw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_sw_ctrl
// Description : Break-before-make sequencer for a gated 2:1 clock select.
//               Gates the clock off, settles, moves the select, settles,
//               restores the gate, settles, then pulses done. Drives control
//               levels only.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sw_ctrl
    import clk_sw_pkg::*;
#(
    parameter int   CNT_W   = CLK_SW_CNT_W,
    parameter logic RST_SEL = 1'b0,
    parameter logic RST_EN  = 1'b1
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    clk_sw_ctrl_if.slave bus
);

    state_e           r_state;
    logic             r_sel;
    logic             r_en;
    logic             r_busy;
    logic             r_done;
    logic             r_tgt_sel;
    logic             r_tgt_en;
    logic [CNT_W-1:0] r_s;

    logic             w_ready;
    logic             w_accept;
    logic [CNT_W-1:0] w_s;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_last;

    // Only combinational output: ready must drop during reset itself
    assign w_ready  = (r_state == IDLE) && !rst_i;
    assign w_accept = bus.req_valid_i && w_ready;

    // A zero settle request would never reach the last-cycle flag, so clamp to 1
    assign w_s = (bus.settle_i == '0) ? CNT_W'(1) : bus.settle_i;

    // Counter control: load at the start of each wait phase, count down inside it
    always_comb begin
        w_load     = 1'b0;
        w_load_val = r_s;
        w_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                w_load_val = w_s;
                if (w_accept && ((bus.req_sel_i != r_sel) || (bus.req_en_i != r_en))) begin
                    w_load = 1'b1;
                end
            end
            OFF_WAIT: begin
                w_dec  = 1'b1;
                w_load = w_last;
            end
            SEL_WAIT: begin
                w_dec  = 1'b1;
                w_load = w_last && r_tgt_en;
            end
            ON_WAIT: begin
                w_dec = 1'b1;
            end
            default: begin
                w_dec = 1'b0;
            end
        endcase
    end

    clk_sw_settle_cnt #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .dec_i      (w_dec),
        .is_last_o  (w_last)
    );

    // Sequencer: select and enable are only ever updated in different states,
    // and the select only moves while the gate is held off
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_sel     <= RST_SEL;
            r_en      <= RST_EN;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tgt_sel <= 1'b0;
            r_tgt_en  <= 1'b0;
            r_s       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tgt_sel <= bus.req_sel_i;
                        r_tgt_en  <= bus.req_en_i;
                        r_s       <= w_s;
                        r_busy    <= 1'b1;
                        if (bus.req_sel_i != r_sel) begin
                            // Force the gate off even if it already is
                            r_en    <= 1'b0;
                            r_state <= OFF_WAIT;
                        end else begin
                            r_en <= bus.req_en_i;
                            if (bus.req_en_i != r_en) begin
                                r_state <= ON_WAIT;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                OFF_WAIT: begin
                    if (w_last) begin
                        r_sel   <= r_tgt_sel;
                        r_state <= SEL_WAIT;
                    end
                end
                SEL_WAIT: begin
                    if (w_last) begin
                        r_en <= r_tgt_en;
                        if (r_tgt_en) begin
                            r_state <= ON_WAIT;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ON_WAIT: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.clk_sel_o   = r_sel;
    assign bus.clk_en_o    = r_en;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_clk_sw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_sw_ctrl
// Description : Self-checking bench for clk_sw_ctrl. Per-scenario tasks check
//               cycle-by-cycle timing; a scoreboard queue holds the final
//               select/enable expected at each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_sw_ctrl;

    typedef struct {
        logic sel;
        logic en;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    logic prev_sel;
    logic prev_en;
    logic prev_rst;

    always #5 clk = ~clk;

    clk_sw_ctrl_if #(.CNT_W(8)) bus ();

    clk_sw_ctrl #(
        .CNT_W   (8),
        .RST_SEL (1'b0),
        .RST_EN  (1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Advance one cycle, then check the switching invariant and the scoreboard
    task automatic step();
        exp_t e;
        prev_sel = bus.clk_sel_o;
        prev_en  = bus.clk_en_o;
        prev_rst = rst;
        @(posedge clk);
        #1;
        if (!prev_rst && (bus.clk_sel_o !== prev_sel)) begin
            n_tests++;
            if ((prev_en !== 1'b0) || (bus.clk_en_o !== prev_en)) begin
                n_fail++;
                $display("FAIL invariant: sel %b->%b with en %b->%b, required en 0 and stable",
                         prev_sel, bus.clk_sel_o, prev_en, bus.clk_en_o);
            end
        end
        if (bus.done_o === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: done_o pulsed with no outstanding request");
            end else begin
                e = sb.pop_front();
                if ((bus.clk_sel_o !== e.sel) || (bus.clk_en_o !== e.en)) begin
                    n_fail++;
                    $display("FAIL scoreboard: at done sel/en=%b%b, required %b%b",
                             bus.clk_sel_o, bus.clk_en_o, e.sel, e.en);
                end
            end
        end
    endtask

    // Present a single request for one edge and record its expected outcome
    task automatic send(input logic s, input logic en, input logic [7:0] st);
        bus.req_valid_i = 1'b1;
        bus.req_sel_i   = s;
        bus.req_en_i    = en;
        bus.settle_i    = st;
        sb.push_back('{sel: s, en: en});
        step();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_sel_i   = 1'b0;
        bus.req_en_i    = 1'b0;
        bus.settle_i    = 8'd0;
        step(); step(); step();
        got = {bus.clk_sel_o, bus.clk_en_o, bus.busy_o, bus.done_o, bus.req_ready_o};
        n_tests++;
        if (got !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_state: sel,en,busy,done,ready=%b required 01000", got);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: ready=%b required 1", bus.req_ready_o);
        end
    endtask

    // sel 0->1 keeping the gate on, S=4
    task automatic test_full_switch();
        logic [4:0] got, exp_v;
        send(1'b1, 1'b1, 8'd4);
        for (int k = 1; k <= 14; k++) begin
            got   = {bus.clk_sel_o, bus.clk_en_o, bus.done_o, bus.req_ready_o, bus.busy_o};
            exp_v = {k >= 5, k >= 9, k == 13, k >= 14, k <= 13};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL full_switch cyc %0d: sel,en,done,ready,busy=%b required %b", k, got, exp_v);
            end
            if (k < 14) step();
        end
    endtask

    // sel 1->0 ending with the gate off, S=2
    task automatic test_gate_off();
        logic [4:0] got, exp_v;
        send(1'b0, 1'b0, 8'd2);
        for (int k = 1; k <= 6; k++) begin
            got   = {bus.clk_sel_o, bus.clk_en_o, bus.done_o, bus.req_ready_o, bus.busy_o};
            exp_v = {k < 3, 1'b0, k == 5, k >= 6, k <= 5};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL gate_off cyc %0d: sel,en,done,ready,busy=%b required %b", k, got, exp_v);
            end
            if (k < 6) step();
        end
    endtask

    // Request equal to current state, then en-only change with settle 0
    task automatic test_noop_settle_zero();
        logic [4:0] got, exp_v;
        send(1'b0, 1'b0, 8'd5);
        for (int k = 1; k <= 2; k++) begin
            got   = {bus.clk_sel_o, bus.clk_en_o, bus.done_o, bus.req_ready_o, bus.busy_o};
            exp_v = {1'b0, 1'b0, k == 1, k >= 2, k == 1};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL noop cyc %0d: sel,en,done,ready,busy=%b required %b", k, got, exp_v);
            end
            if (k < 2) step();
        end
        send(1'b0, 1'b1, 8'd0);
        for (int k = 1; k <= 3; k++) begin
            got   = {bus.clk_sel_o, bus.clk_en_o, bus.done_o, bus.req_ready_o, bus.busy_o};
            exp_v = {1'b0, 1'b1, k == 2, k == 3, k <= 2};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL settle_zero cyc %0d: sel,en,done,ready,busy=%b required %b", k, got, exp_v);
            end
            if (k < 3) step();
        end
    endtask

    // Reset asserted while waiting after the select change
    task automatic test_reset_mid();
        logic [4:0] got, exp_v;
        send(1'b1, 1'b1, 8'd3);
        for (int k = 1; k <= 5; k++) begin
            got   = {bus.clk_sel_o, bus.clk_en_o, bus.done_o, bus.req_ready_o, bus.busy_o};
            exp_v = {k >= 4, 1'b0, 1'b0, 1'b0, 1'b1};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc %0d: sel,en,done,ready,busy=%b required %b", k, got, exp_v);
            end
            if (k < 5) step();
        end
        rst = 1'b1;
        step();
        got = {bus.clk_sel_o, bus.clk_en_o, bus.done_o, bus.req_ready_o, bus.busy_o};
        n_tests++;
        if (got !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_mid_abort: sel,en,done,ready,busy=%b required 01000", got);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++;
            if ((bus.done_o !== 1'b0) || (bus.busy_o !== 1'b0)) begin
                n_fail++;
                $display("FAIL reset_mid_quiet cyc %0d: done,busy=%b%b required 00", k, bus.done_o, bus.busy_o);
            end
        end
        n_tests++;
        if (sb.size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_pending: queue size %0d required 1", sb.size());
        end
        sb.delete();
    endtask

    // Valid held high with scrambled fields while busy; second request follows done
    task automatic test_back_to_back();
        logic [4:0] got, exp_v;
        bus.req_valid_i = 1'b1;
        bus.req_sel_i   = 1'b1;
        bus.req_en_i    = 1'b1;
        bus.settle_i    = 8'd2;
        sb.push_back('{sel: 1'b1, en: 1'b1});
        step();
        for (int k = 1; k <= 8; k++) begin
            got   = {bus.clk_sel_o, bus.clk_en_o, bus.done_o, bus.req_ready_o, bus.busy_o};
            exp_v = {k >= 3, k >= 5, k == 7, k == 8, k <= 7};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_first cyc %0d: sel,en,done,ready,busy=%b required %b", k, got, exp_v);
            end
            if (k < 8) begin
                bus.req_sel_i = 1'($urandom_range(0, 1));
                bus.req_en_i  = 1'($urandom_range(0, 1));
                bus.settle_i  = 8'($urandom_range(0, 255));
                step();
            end
        end
        bus.req_sel_i = 1'b1;
        bus.req_en_i  = 1'b0;
        bus.settle_i  = 8'd2;
        sb.push_back('{sel: 1'b1, en: 1'b0});
        step();
        bus.req_valid_i = 1'b0;
        for (int m = 1; m <= 4; m++) begin
            got   = {bus.clk_sel_o, bus.clk_en_o, bus.done_o, bus.req_ready_o, bus.busy_o};
            exp_v = {1'b1, 1'b0, m == 3, m >= 4, m <= 3};
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_second cyc %0d: sel,en,done,ready,busy=%b required %b", m, got, exp_v);
            end
            if (m < 4) step();
        end
    endtask

    initial begin
        test_reset();
        test_full_switch();
        test_gate_off();
        test_noop_settle_zero();
        test_reset_mid();
        test_back_to_back();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d requests never completed, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/clk_sw_ctrl.md
Name: clk_sw_ctrl

Overview:
- Sequencer for a gated clock-select path: one 2:1 clock mux select plus one downstream clock-gate enable.
- Performs a break-before-make switch: gate off, wait, change select, wait, restore gate, wait, then report done.
- Runs in a single always-on clock domain. Sits between a CSR/power-management requester and the tech-cell clock mux/gate.
- Drives control levels only; it instantiates no clock cells itself.

Parameters:
- CNT_W, 8, width of the settle counter and of settle_i.
- RST_SEL, 1'b0, reset value of clk_sel_o.
- RST_EN, 1'b1, reset value of clk_en_o.

Ports:
- clk_i  in  1  always-on control clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_sel_i  in  1  target mux select.
- req_en_i  in  1  target gate enable after the request completes.
- settle_i  in  CNT_W  settle cycles per wait phase; value 0 is treated as 1.
- clk_sel_o  out  1  registered mux select.
- clk_en_o  out  1  registered clock-gate enable.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - Synchronous: on any edge with rst_i=1 the controller enters state IDLE.
  - clk_sel_o=RST_SEL, clk_en_o=RST_EN, done_o=0, busy_o=0, counter=0.
  - req_ready_o=0 while rst_i=1.
  - Reset mid-sequence aborts immediately with no intermediate states. The request is not completed and done_o is not pulsed.
- States: IDLE, OFF_WAIT, SEL_WAIT, ON_WAIT, DONE.
- All outputs are registered except req_ready_o = (state==IDLE) && !rst_i.
- Accept:
  - A request is accepted on an edge where req_valid_i && req_ready_o.
  - At that edge the controller latches tgt_sel, tgt_en and S = max(settle_i,1).
  - Inputs are ignored outside IDLE. Holding req_valid_i while busy has no effect until ready returns.
- Select-change path (tgt_sel != clk_sel_o), accept at edge t:
  - Edge t: clk_en_o<=0 (forced even if already 0), cnt<=S, go to OFF_WAIT.
  - OFF_WAIT: cnt decrements each cycle. On the edge where cnt==1: clk_sel_o<=tgt_sel, cnt<=S, go to SEL_WAIT.
  - SEL_WAIT: on the edge where cnt==1: clk_en_o<=tgt_en. If tgt_en=1: cnt<=S, go to ON_WAIT; else go to DONE.
  - ON_WAIT: on the edge where cnt==1, go to DONE.
  - DONE: done_o=1 for exactly that cycle, next edge goes to IDLE.
  - Resulting timing (tgt_en=1): clk_en_o low from cycle t+1; clk_sel_o new from t+S+1; clk_en_o high from t+2S+1; done_o at t+3S+1; req_ready_o at t+3S+2.
  - With tgt_en=0: done_o at t+2S+1.
- Same-select path (tgt_sel == clk_sel_o):
  - Edge t: clk_en_o<=tgt_en.
  - If tgt_en differs from the old clk_en_o: cnt<=S, go to ON_WAIT (enable and disable both wait S). done_o at t+S+1.
  - If tgt_en is unchanged (no-op): go to DONE directly. done_o at t+1.
- Invariants:
  - clk_sel_o never changes while clk_en_o=1.
  - clk_sel_o and clk_en_o never change in the same cycle.
- Counter: unsigned CNT_W, no wrap. A load of 0 is impossible because S is at least 1.

Decomposition:
- Package clk_sw_pkg holds:
  - state_e enum (IDLE, OFF_WAIT, SEL_WAIT, ON_WAIT, DONE);
  - default CNT_W constant.
- One sub-module, clk_sw_settle_cnt: load/decrement counter with an is_last (cnt==1) flag, parameterised on CNT_W.
- The top-level integration instantiates clk_sw_ctrl next to tc_clk_mux2 and the clock gate.

Test Plan:
- Reset defaults: rst_i held 3 cycles -> clk_sel_o=0, clk_en_o=1, busy_o=0, done_o=0, req_ready_o=0; after release req_ready_o=1.
- Full switch, S=4: request sel=1 en=1 at cycle 0 -> clk_en_o=0 @1, clk_sel_o=1 @5, clk_en_o=1 @9, done_o=1 @13 only, req_ready_o=1 @14.
- Switch to gated-off, S=2: request sel=0 en=0 from sel=1 en=1 -> clk_en_o=0 @1, clk_sel_o=0 @3, clk_en_o stays 0, done_o @5.
- No-op and settle_i=0:
  - Request matching current state -> done_o @1, outputs unchanged.
  - Request en-only change with settle_i=0 -> treated as S=1, done_o @2.
- Reset mid-sequence: assert rst_i during SEL_WAIT -> next cycle clk_sel_o=RST_SEL, clk_en_o=RST_EN, busy_o=0, no done_o pulse.
- Back-pressure and invariant check:
  - req_valid_i held high through a whole sequence with changing req_sel_i -> only the accepted values are applied.
  - A second request is accepted only after done_o.
  - Assertion: clk_sel_o never toggles while clk_en_o=1.
